// File: rtl/multu_seq.sv
// multu_seq: EX-stage unsigned multiply sequencer that owns the HI/LO registers.
// Latency: multu accepted in cycle 0 -> busy cycles 1..WIDTH -> HI/LO readable from cycle WIDTH+1.
// Backpressure: a multu/mfhi/mflo reaching EX while a multiply runs raises stall (combinational).
//
// Ports: clk/rst (sync, active-high); op_valid + ALUOperation select the request;
//        src_a/src_b are operands sampled only on acceptance; stall/busy report the
//        in-flight multiply; hilo_rd/hilo_out supply mfhi/mflo results; hi/lo are the
//        architectural registers.
module multu_seq #(
    parameter int         WIDTH   = 32,
    parameter logic [5:0] F_MULTU = 6'd25,
    parameter logic [5:0] F_MFHI  = 6'd16,
    parameter logic [5:0] F_MFLO  = 6'd18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [5:0]       ALUOperation,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             stall,
    output logic             busy,
    output logic             hilo_rd,
    output logic [WIDTH-1:0] hilo_out,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] product_step;
    logic [WIDTH:0]     step_sum;

    logic is_multu;
    logic is_mfhi;
    logic is_mflo;
    logic hilo_op;
    logic start;
    logic last_step;

    // Request decode: anything without op_valid, or any other code, is ignored.
    assign is_multu  = op_valid && (ALUOperation == F_MULTU);
    assign is_mfhi   = op_valid && (ALUOperation == F_MFHI);
    assign is_mflo   = op_valid && (ALUOperation == F_MFLO);
    assign hilo_op   = is_multu || is_mfhi || is_mflo;
    assign start     = (state == IDLE) && is_multu;
    assign last_step = (state == RUN) && (count == CW'(WIDTH - 1));

    // One shift-add step: the low half starts as the multiplier and is consumed
    // LSB first; the carry out of the add shifts into the top bit.
    assign step_sum     = {1'b0, product[2*WIDTH-1:WIDTH]}
                        + (product[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    assign product_step = {step_sum, product[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (is_multu)  state_nxt = RUN;
            RUN:     if (last_step) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy     = (state == RUN);
        stall    = hilo_op && (state == RUN);
        hilo_rd  = (state == IDLE) && (is_mfhi || is_mflo);
        hilo_out = '0;
        if (hilo_rd) begin
            hilo_out = is_mfhi ? hi : lo;
        end
    end

    // Datapath: operands, running product, step counter and HI/LO.
    // HI/LO are written from the post-step product so the final step lands
    // on the same edge that returns the FSM to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            mcand   <= '0;
            product <= '0;
            hi      <= '0;
            lo      <= '0;
        end else if (start) begin
            mcand   <= src_a;
            product <= {{WIDTH{1'b0}}, src_b};
            count   <= '0;
        end else if (state == RUN) begin
            product <= product_step;
            if (last_step) begin
                count <= '0;
                hi    <= product_step[2*WIDTH-1:WIDTH];
                lo    <= product_step[WIDTH-1:0];
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multu_seq.sv
// tb_multu_seq: self-checking bench for multu_seq.
// Reference model tracks HI/LO, a pending product and a busy-cycles-remaining counter;
// a negedge compare process checks every output every cycle, directed blocks pin literals.
module tb_multu_seq;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           op_valid;
    logic [5:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           stall;
    logic           busy;
    logic           hilo_rd;
    logic [W-1:0]   hilo_out;
    logic [W-1:0]   hi;
    logic [W-1:0]   lo;

    always #5 clk = ~clk;

    multu_seq #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .op_valid     (op_valid),
        .ALUOperation (op),
        .src_a        (a),
        .src_b        (b),
        .stall        (stall),
        .busy         (busy),
        .hilo_rd      (hilo_rd),
        .hilo_out     (hilo_out),
        .hi           (hi),
        .lo           (lo)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0]   m_hi   = '0;
    logic [W-1:0]   m_lo   = '0;
    logic [2*W-1:0] m_pend = '0;
    int             m_rem  = 0;   // busy cycles still to come; 0 means idle

    always @(posedge clk) begin
        if (rst) begin
            m_hi  = '0;
            m_lo  = '0;
            m_rem = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) {m_hi, m_lo} = m_pend;
        end else if (op_valid && op == 6'd25) begin
            m_pend = 64'(a) * 64'(b);
            m_rem  = W;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic         e_busy, e_hop, e_rd;
    logic [W-1:0] e_out;

    always @(negedge clk) begin
        if (chk_en) begin
            e_busy = (m_rem > 0);
            e_hop  = op_valid && (op == 6'd25 || op == 6'd16 || op == 6'd18);
            e_rd   = op_valid && (op == 6'd16 || op == 6'd18) && !e_busy;
            e_out  = e_rd ? ((op == 6'd16) ? m_hi : m_lo) : '0;
            check("busy",     busy,     e_busy);
            check("stall",    stall,    e_hop && e_busy);
            check("hilo_rd",  hilo_rd,  e_rd);
            check("hilo_out", hilo_out, e_out);
            check("hi",       hi,       m_hi);
            check("lo",       lo,       m_lo);
        end
    end

    // ---------------- stimulus ----------------
    // One call = one cycle; inputs change just after the rising edge.
    task automatic drive(input bit v, input logic [5:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input bit r = 1'b0);
        @(posedge clk);
        #1;
        rst      = r;
        op_valid = v;
        op       = o;
        a        = x;
        b        = y;
    endtask

    task automatic idle();
        drive(1'b0, 6'($urandom), $urandom, $urandom);
    endtask

    task automatic peek();
        #3;
    endtask

    int cnt;
    int cyc;

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; op_valid = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;

        // Reset + 5 idle cycles, then mflo reads 0 without stall.
        for (int i = 0; i < 5; i++) begin
            idle();
            peek();
        end
        check("rst_busy", busy, 1'b0);
        check("rst_hi", hi, '0);
        check("rst_lo", lo, '0);
        drive(1'b1, 6'd18, '0, '0);
        peek();
        check("rst_mflo_rd", hilo_rd, 1'b1);
        check("rst_mflo_out", hilo_out, '0);
        check("rst_mflo_stall", stall, 1'b0);

        // Max operands: busy exactly cycles 1..32.
        drive(1'b1, 6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF);
        peek();
        check("max_busy_c0", busy, 1'b0);
        cnt = 0;
        for (int i = 1; i <= W; i++) begin
            idle();
            peek();
            if (busy) cnt++;
        end
        check("max_busy_cycles", 64'(cnt), 64'd32);
        idle();
        peek();
        check("max_busy_c33", busy, 1'b0);
        check("max_hi", hi, 32'hFFFFFFFE);
        check("max_lo", lo, 32'h00000001);
        check("model_max_hi", m_hi, 32'hFFFFFFFE);

        // 7*6 with mflo waiting in EX from cycle 1.
        drive(1'b1, 6'd25, 32'd7, 32'd6);
        cnt = 0;
        for (int i = 1; i <= W; i++) begin
            drive(1'b1, 6'd18, $urandom, $urandom);
            peek();
            if (stall && !hilo_rd) cnt++;
        end
        check("mflo_stall_cycles", 64'(cnt), 64'd32);
        drive(1'b1, 6'd18, '0, '0);
        peek();
        check("mflo_c33_stall", stall, 1'b0);
        check("mflo_c33_rd", hilo_rd, 1'b1);
        check("mflo_c33_out", hilo_out, 32'd42);
        drive(1'b1, 6'd16, '0, '0);
        peek();
        check("mfhi_after_stall", stall, 1'b0);
        check("mfhi_after_out", hilo_out, 32'd0);
        check("model_lo_42", m_lo, 32'd42);

        // Back-to-back multu: second is held off until cycle 33.
        drive(1'b1, 6'd25, 32'd3, 32'd5);
        cyc = 1;
        drive(1'b1, 6'd25, 32'h10000, 32'h10000);
        peek();
        while (stall && cyc < 40) begin
            cyc++;
            drive(1'b1, 6'd25, 32'h10000, 32'h10000);
            peek();
        end
        check("b2b_accept_cycle", 64'(cyc), 64'd33);
        check("b2b_mid_lo", lo, 32'd15);
        for (int i = 0; i < W; i++) idle();
        idle();
        peek();
        check("b2b_hi", hi, 32'd1);
        check("b2b_lo", lo, 32'd0);
        check("model_b2b_hi", m_hi, 32'd1);

        // Reset aborts a multiply in flight.
        drive(1'b1, 6'd25, 32'd9, 32'd9);
        for (int i = 1; i <= 9; i++) idle();
        drive(1'b0, 6'd0, '0, '0, 1'b1);
        idle();
        peek();
        check("abort_busy", busy, 1'b0);
        for (int i = 0; i < 40; i++) idle();
        peek();
        check("abort_hi", hi, '0);
        check("abort_lo", lo, '0);

        // Unrelated ops and invalid multu during RUN: no stall, no restart.
        drive(1'b1, 6'd25, 32'd5, 32'd5);
        cnt = 0;
        cyc = 0;
        for (int i = 1; i <= W; i++) begin
            if (i % 2 == 1) drive(1'b1, 6'd32, $urandom, $urandom);
            else            drive(1'b0, 6'd25, $urandom, $urandom);
            peek();
            if (busy)  cnt++;
            if (stall) cyc++;
        end
        check("ign_busy_cycles", 64'(cnt), 64'd32);
        check("ign_stall_cycles", 64'(cyc), 64'd0);
        drive(1'b0, 6'd25, 32'd2, 32'd2);
        peek();
        check("ign_c33_busy", busy, 1'b0);
        idle();
        peek();
        check("ign_no_restart", busy, 1'b0);
        check("ign_lo", lo, 32'd25);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] o;
            case ($urandom_range(0, 4))
                0:       o = 6'd25;
                1:       o = 6'd16;
                2:       o = 6'd18;
                3:       o = 6'd32;
                default: o = 6'($urandom);
            endcase
            drive($urandom_range(0, 3) != 0, o, $urandom, $urandom,
                  $urandom_range(0, 199) == 0);
        end
        drive(1'b0, 6'd0, '0, '0);
        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
